// File: rtl/mem_bus_arbiter.sv
// Merges the instruction-fetch and data request channels onto one single-beat memory bus.
// Data wins arbitration, except that a waiting fetch is granted after STARVE_LIMIT data grants in a row.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [2:0]  creq_size,
  output logic [63:0] creq_addr,
  output logic [7:0]  creq_strobe,
  output logic [63:0] creq_data,
  input  logic        cresp_ready,
  input  logic        cresp_last,
  input  logic [63:0] cresp_data,
  output logic        err_timeout
);

  localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t              state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                lane_hi;

  logic                starve_hit_c;
  logic                timeout_hit_c;
  logic                beat_done_c;
  logic [63:0]         rdata_c;

  // A forced completion returns zero data in place of the memory beat.
  always_comb begin
    starve_hit_c  = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    timeout_hit_c = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT));
    beat_done_c   = cresp_ready && cresp_last;
    rdata_c       = beat_done_c ? cresp_data : 64'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      wait_cnt      <= '0;
      lane_hi       <= 1'b0;
      creq_valid    <= 1'b0;
      creq_is_write <= 1'b0;
      creq_size     <= 3'd0;
      creq_addr     <= 64'h0;
      creq_strobe   <= 8'h0;
      creq_data     <= 64'h0;
      iresp_addr_ok <= 1'b0;
      iresp_data_ok <= 1'b0;
      iresp_data    <= 32'h0;
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= 64'h0;
      err_timeout   <= 1'b0;
    end else begin
      iresp_addr_ok <= 1'b0;
      iresp_data_ok <= 1'b0;
      dresp_addr_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      err_timeout   <= 1'b0;

      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (dreq_valid && !(ireq_valid && starve_hit_c)) begin
            creq_valid    <= 1'b1;
            creq_is_write <= |dreq_strobe;
            creq_size     <= dreq_size;
            creq_addr     <= dreq_addr;
            creq_strobe   <= dreq_strobe;
            creq_data     <= dreq_data;
            if (ireq_valid && !starve_hit_c) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
            state <= GRANT_D;
          end else if (ireq_valid) begin
            // Fetches are always full aligned doublewords; addr[2] picks the lane on return.
            creq_valid    <= 1'b1;
            creq_is_write <= 1'b0;
            creq_size     <= 3'd3;
            creq_addr     <= ireq_addr & ~64'h7;
            creq_strobe   <= 8'h0;
            creq_data     <= 64'h0;
            lane_hi       <= ireq_addr[2];
            starve_cnt    <= '0;
            state         <= GRANT_I;
          end
        end

        GRANT_I, GRANT_D: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (beat_done_c || timeout_hit_c) begin
            creq_valid  <= 1'b0;
            err_timeout <= !beat_done_c;
            if (state == GRANT_I) begin
              iresp_addr_ok <= 1'b1;
              iresp_data_ok <= 1'b1;
              iresp_data    <= lane_hi ? rdata_c[63:32] : rdata_c[31:0];
            end else begin
              dresp_addr_ok <= 1'b1;
              dresp_data_ok <= 1'b1;
              dresp_data    <= rdata_c;
            end
            state <= RESP;
          end
        end

        RESP: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, payload and response rules.
module tb_mem_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset, reset_to;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        cresp_ready, cresp_last, cresp_ready_to;
  logic [63:0] cresp_data, cresp_data_to;

  logic        iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok;
  logic [31:0] iresp_data;
  logic [63:0] dresp_data;
  logic        creq_valid, creq_is_write, err_timeout;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr, creq_data;
  logic [7:0]  creq_strobe;

  logic        t_iresp_addr_ok, t_iresp_data_ok, t_dresp_addr_ok, t_dresp_data_ok;
  logic [31:0] t_iresp_data;
  logic [63:0] t_dresp_data;
  logic        t_creq_valid, t_creq_is_write, t_err_timeout;
  logic [2:0]  t_creq_size;
  logic [63:0] t_creq_addr, t_creq_data;
  logic [7:0]  t_creq_strobe;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(1023)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
    .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
    .err_timeout(err_timeout)
  );

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(8)) dut_to (
    .clk(clk), .reset(reset_to),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(t_iresp_addr_ok), .iresp_data_ok(t_iresp_data_ok), .iresp_data(t_iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(t_dresp_addr_ok), .dresp_data_ok(t_dresp_data_ok), .dresp_data(t_dresp_data),
    .creq_valid(t_creq_valid), .creq_is_write(t_creq_is_write), .creq_size(t_creq_size),
    .creq_addr(t_creq_addr), .creq_strobe(t_creq_strobe), .creq_data(t_creq_data),
    .cresp_ready(cresp_ready_to), .cresp_last(cresp_last), .cresp_data(cresp_data_to),
    .err_timeout(t_err_timeout)
  );

  int checks = 0;
  int failures = 0;

  // Requester and model state
  bit          i_act, d_act;
  logic [63:0] i_addr, d_addr, d_data;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  bit          in_grant, exp_resp, grant_d;
  int          gcyc, starve, idle_cycles;
  logic [63:0] exp_data;
  int          ready_delay;
  bit          rand_issue, both_hold, use_next_rdata;
  logic [63:0] next_rdata;
  logic [9:0]  gbits;
  int          gcount;
  logic [63:0] snap_addr, last_resp_data;
  logic [11:0] snap_ctl;
  int          last_gcyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drive();
    ireq_valid  = i_act;
    ireq_addr   = i_addr;
    dreq_valid  = d_act;
    dreq_addr   = d_addr;
    dreq_size   = d_size;
    dreq_strobe = d_strobe;
    dreq_data   = d_data;
  endtask

  task automatic new_fetch(input logic [63:0] a);
    i_act = 1'b1; i_addr = a;
  endtask

  task automatic new_data(input logic [63:0] a, input logic [2:0] sz,
                          input logic [7:0] st, input logic [63:0] dt);
    d_act = 1'b1; d_addr = a; d_size = sz; d_strobe = st; d_data = dt;
  endtask

  // One clock: check outputs at the falling edge, then drive memory and requesters.
  task automatic step();
    bit exp_d, dut_d, rdy;
    logic [63:0] rd;
    @(negedge clk);
    if (exp_resp) begin
      if (grant_d) begin
        chk("dresp_ok_pair", 64'({dresp_addr_ok, dresp_data_ok}), 64'h3);
        chk("dresp_data", dresp_data, exp_data);
        chk("iresp_quiet", 64'(iresp_data_ok), 64'h0);
        last_resp_data = dresp_data;
        if (!both_hold) d_act = 1'b0;
      end else begin
        chk("iresp_ok_pair", 64'({iresp_addr_ok, iresp_data_ok}), 64'h3);
        chk("iresp_data", 64'(iresp_data), exp_data);
        chk("dresp_quiet", 64'(dresp_data_ok), 64'h0);
        last_resp_data = 64'(iresp_data);
        if (!both_hold) i_act = 1'b0;
      end
      chk("resp_creq_low", 64'(creq_valid), 64'h0);
      last_gcyc = gcyc;
      exp_resp = 1'b0;
      in_grant = 1'b0;
      idle_cycles = 0;
    end else begin
      chk("no_resp_pulse", 64'({iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}), 64'h0);
      if (creq_valid) begin
        if (!in_grant) begin
          exp_d = d_act && !(i_act && starve == LIMIT);
          dut_d = d_act && creq_addr == d_addr && creq_strobe == d_strobe && creq_size == d_size;
          chk("grant_choice", 64'(dut_d), 64'(exp_d));
          chk("issue_latency", 64'(idle_cycles > 1), 64'h0);
          if (exp_d) begin
            if (i_act && starve < LIMIT) starve++;
          end else begin
            starve = 0;
          end
          gbits = {gbits[8:0], !exp_d};
          gcount++;
          grant_d = exp_d;
          in_grant = 1'b1;
          gcyc = 0;
          snap_addr = creq_addr;
          snap_ctl = {creq_is_write, creq_size, creq_strobe};
        end
        gcyc++;
        idle_cycles = 0;
        if (grant_d) begin
          chk("creq_addr_d", creq_addr, d_addr);
          chk("creq_ctl_d", 64'({creq_is_write, creq_size, creq_strobe}), 64'({|d_strobe, d_size, d_strobe}));
          chk("creq_data_d", creq_data, d_data);
        end else begin
          chk("creq_addr_i", creq_addr, i_addr & ~64'h7);
          chk("creq_ctl_i", 64'({creq_is_write, creq_size, creq_strobe}), 64'({1'b0, 3'd3, 8'h00}));
        end
      end else if (in_grant) begin
        chk("creq_valid_held", 64'(creq_valid), 64'h1);
      end else if (i_act || d_act) begin
        idle_cycles++;
      end else begin
        idle_cycles = 0;
      end
    end

    // Memory side: stray ready pulses outside a grant must be ignored.
    if (in_grant && creq_valid) begin
      rdy = (ready_delay < 0) ? ($urandom_range(0, 2) == 0) : (gcyc == ready_delay + 1);
      rd = use_next_rdata ? next_rdata : {$urandom, $urandom};
      cresp_ready = rdy;
      cresp_last  = 1'b1;
      cresp_data  = rd;
      if (rdy) begin
        exp_resp = 1'b1;
        exp_data = grant_d ? rd : (i_addr[2] ? 64'(rd[63:32]) : 64'(rd[31:0]));
      end
    end else begin
      cresp_ready = 1'($urandom_range(0, 1));
      cresp_last  = 1'b1;
      cresp_data  = {$urandom, $urandom};
    end

    if (rand_issue) begin
      if (!i_act && $urandom_range(0, 2) == 0)
        new_fetch({32'h0, 16'h8000, 16'($urandom)});
      if (!d_act && $urandom_range(0, 2) == 0)
        new_data({32'h0, 16'h9000, 16'($urandom)}, 3'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom});
    end
    drive();
  endtask

  task automatic run_until_idle(input int bound, input string tag);
    for (int k = 0; k < bound && (i_act || d_act || in_grant); k++) step();
    chk(tag, 64'({i_act, d_act, in_grant}), 64'h0);
  endtask

  initial begin
    bit seen;
    int tc;
    reset = 1'b1; reset_to = 1'b1;
    i_act = 0; d_act = 0; i_addr = 0; d_addr = 0; d_size = 0; d_strobe = 0; d_data = 0;
    in_grant = 0; exp_resp = 0; grant_d = 0; gcyc = 0; starve = 0; idle_cycles = 0;
    ready_delay = 0; rand_issue = 0; both_hold = 0; use_next_rdata = 0; next_rdata = 0;
    gbits = '0; gcount = 0; exp_data = 0; last_resp_data = 0; last_gcyc = 0;
    cresp_ready = 0; cresp_last = 1; cresp_data = 0; cresp_ready_to = 0; cresp_data_to = 0;
    drive();
    repeat (3) @(negedge clk);
    chk("rst_creq_valid", 64'(creq_valid), 64'h0);
    chk("rst_creq_fields", creq_addr | creq_data | 64'({creq_is_write, creq_size, creq_strobe}), 64'h0);
    chk("rst_resp", 64'({iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok, err_timeout}), 64'h0);
    reset = 1'b0;

    // Fetch with upper-lane address
    use_next_rdata = 1; next_rdata = 64'h1111_2222_3333_4444; ready_delay = 1;
    new_fetch(64'h8000_0004); drive();
    run_until_idle(20, "t1_done");
    chk("t1_creq_addr", snap_addr, 64'h8000_0000);
    chk("t1_is_write", 64'(snap_ctl[11]), 64'h0);
    chk("t1_fetch_data", last_resp_data, 64'h1111_2222);

    // Data write
    ready_delay = 0;
    new_data(64'h8000_1000, 3'd2, 8'h0F, 64'hDEAD_BEEF); drive();
    run_until_idle(20, "t2_done");
    chk("t2_ctl", 64'(snap_ctl), 64'({1'b1, 3'd2, 8'h0F}));
    chk("t2_data_back", last_resp_data, 64'h1111_2222_3333_4444);
    use_next_rdata = 0;

    // Both channels held continuously
    both_hold = 1; gbits = '0; gcount = 0;
    new_fetch(64'h8000_0100); new_data(64'h9000_0200, 3'd3, 8'h00, 64'h0); drive();
    for (int k = 0; k < 200 && gcount < 10; k++) step();
    chk("t3_grants", 64'(gcount), 64'd10);
    chk("t3_order", 64'(gbits), 64'(10'b0000100001));
    both_hold = 0;
    run_until_idle(40, "t3_drain");

    // Ten-cycle memory stall on a data read
    ready_delay = 10;
    new_data(64'h9000_2000, 3'd3, 8'h00, 64'h0); drive();
    run_until_idle(40, "t4_done");
    chk("t4_grant_cycles", 64'(last_gcyc), 64'd11);

    // Randomized traffic
    ready_delay = -1; rand_issue = 1;
    repeat (600) step();
    rand_issue = 0;
    run_until_idle(200, "rand_drain");

    // Asynchronous reset in the middle of a fetch grant
    ready_delay = 1000;
    new_fetch(64'h8000_0040); drive();
    for (int k = 0; k < 10 && !in_grant; k++) step();
    step(); step();
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t5_creq_drop", 64'(creq_valid), 64'h0);
    chk("t5_no_iresp", 64'({iresp_addr_ok, iresp_data_ok}), 64'h0);
    i_act = 0; in_grant = 0; exp_resp = 0; starve = 0; idle_cycles = 0; drive();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    ready_delay = 0;
    new_fetch(64'h8000_0080); drive();
    run_until_idle(20, "t5_after_reset");

    // Timeout instance: memory never responds, then responds immediately
    reset = 1'b1;
    @(negedge clk);
    reset_to = 1'b0;
    new_data(64'h9000_3000, 3'd3, 8'h00, 64'h0); drive();
    seen = 0; tc = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (t_dresp_data_ok) begin
        seen = 1;
        chk("t6_err", 64'(t_err_timeout), 64'h1);
        chk("t6_data", t_dresp_data, 64'h0);
        chk("t6_grant_cycles", 64'(tc), 64'd9);
      end else begin
        if (t_creq_valid) tc++;
        chk("t6_no_early_err", 64'(t_err_timeout), 64'h0);
      end
    end
    chk("t6_resp_seen", 64'(seen), 64'h1);
    d_act = 0; drive();
    @(negedge clk);
    cresp_ready_to = 1; cresp_data_to = 64'h0123_4567_89AB_CDEF;
    new_data(64'h9000_4000, 3'd3, 8'h00, 64'h0); drive();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (t_dresp_data_ok) begin
        seen = 1;
        chk("t6_next_data", t_dresp_data, 64'h0123_4567_89AB_CDEF);
        chk("t6_next_err", 64'(t_err_timeout), 64'h0);
      end
    end
    chk("t6_next_seen", 64'(seen), 64'h1);
    d_act = 0; drive();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
